// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flag bank arbiter.
// Optional feature macro: SR_TOGGLE_EN (S=R=1 toggles the flag instead of
// flagging an error).
package sr_pkg;

  localparam int SR_NREQ_DEF  = 4;
  localparam int SR_NFLAG_DEF = 8;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SET  = 2'd1,
    RST  = 2'd2,
    ILL  = 2'd3
  } sr_op_t;

  // Map a requester's S/R bits onto the flag operation it asks for.
  function automatic sr_op_t sr_decode(input logic s, input logic r);
    sr_op_t op;
    case ({s, r})
      2'b10:   op = SET;
      2'b01:   op = RST;
      2'b11:   op = ILL;
      default: op = HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sr_bank_arb_rr.sv
// Round-robin winner selection: the first requester at or after the
// priority pointer (wrapping) with its mask bit set wins.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  // Scan from the pointer position and keep only the first eligible requester.
  always_comb begin
    logic found;
    int   pos;
    win   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!found && req_mask[pos]) begin
        win[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_bank_arb.sv
// Arbitrated SR flag bank: requesters compete round-robin for one command
// slot per cycle; the winning set/reset command is applied one cycle after
// the grant. Optional macro SR_TOGGLE_EN turns S=R=1 into a flag toggle;
// without it S=R=1 leaves the flag alone and raises err / bumps err_cnt.
module sr_bank_arb
  import sr_pkg::*;
#(
  parameter  int NREQ  = SR_NREQ_DEF,
  parameter  int NFLAG = SR_NFLAG_DEF,
  localparam int IW    = $clog2(NFLAG),
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    s_in,
  input  logic [NREQ-1:0]    r_in,
  input  logic [NREQ*IW-1:0] idx,
  output logic [NREQ-1:0]    gnt,
  output logic [NFLAG-1:0]   flags,
  output logic               err,
  output logic [7:0]         err_cnt
);

`ifndef SR_TOGGLE_EN
  // Error counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] win_p0;
  sr_op_t          op_p0;
  logic [IW-1:0]   idx_p0;
  logic [PW-1:0]   wnum_p0;

  sr_op_t          op_p1;
  logic [IW-1:0]   idx_p1;
  logic            vld_p1;

  // ---- stage p0: arbitration (a currently granted requester is excluded) ----
  rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req_mask (req & ~gnt),
    .ptr      (ptr),
    .win      (win_p0)
  );

  // Pick out the winner's command fields and index; next pointer follows it.
  always_comb begin
    op_p0   = HOLD;
    idx_p0  = '0;
    wnum_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_p0[i]) begin
        op_p0   = sr_decode(s_in[i], r_in[i]);
        idx_p0  = idx[i*IW +: IW];
        wnum_p0 = PW'(i);
      end
    end
    ptr_nxt = (wnum_p0 == PW'(NREQ - 1)) ? '0 : wnum_p0 + 1'b1;
  end

  // ---- stage p1: grant and command register ----
  // Register the grant and the winner's command; advance the pointer only on a grant.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gnt    <= '0;
      vld_p1 <= 1'b0;
      op_p1  <= HOLD;
      idx_p1 <= '0;
      ptr    <= '0;
    end else begin
      gnt    <= win_p0;
      vld_p1 <= |win_p0;
      op_p1  <= op_p0;
      idx_p1 <= idx_p0;
      if (|win_p0) begin
        ptr <= ptr_nxt;
      end
    end
  end

  // ---- stage p2: apply latched command to the flag bank ----
  // Only the addressed flag changes; err is a single-cycle pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      flags   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (vld_p1) begin
        case (op_p1)
          SET:  flags[idx_p1] <= 1'b1;
          RST:  flags[idx_p1] <= 1'b0;
          ILL: begin
`ifdef SR_TOGGLE_EN
            flags[idx_p1] <= ~flags[idx_p1];
`else
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
